// File: rtl/counter_pkg.sv
// Shared types for the counter bank: channel mode encoding.
`default_nettype none

package counter_pkg;

  typedef enum logic [1:0] {
    MODE_FREE     = 2'b00,
    MODE_PERIODIC = 2'b01,
    MODE_ONESHOT  = 2'b10,
    MODE_HOLD     = 2'b11
  } mode_t;

  localparam int c_MODE_W = 2;

endpackage

`default_nettype wire

// File: rtl/counter_channel.sv
// One counter channel: count, running status, terminal-count pulse and sticky flag.
`default_nettype none

module counter_channel
  import counter_pkg::*;
#(
  parameter int W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_strobe,
  input  logic                i_load,
  input  logic                i_en,
  input  logic                i_up_down,
  input  logic [c_MODE_W-1:0] i_mode,
  input  logic [W-1:0]        i_reload_val,
  input  logic                i_flag_clr,
  output logic [W-1:0]        o_count,
  output logic                o_tc,
  output logic                o_flag,
  output logic                o_active
);

  localparam logic [W-1:0] c_ONE = W'(1);

  logic [W-1:0] r_count;
  logic         r_active;
  logic         r_tc;
  logic         r_flag;

  mode_t        w_mode;
  logic [W-1:0] w_start;
  logic         w_tick;
  logic         w_terminal;
  logic         w_tc_set;

  assign w_mode  = mode_t'(i_mode);
  assign w_start = i_up_down ? '0 : i_reload_val;
  assign w_tick  = i_en & r_active & i_strobe & (w_mode != MODE_HOLD);

  always_comb begin
    w_terminal = 1'b0;
    case (w_mode)
      MODE_FREE: w_terminal = i_up_down ? (r_count == '1) : (r_count == '0);
      default:   w_terminal = i_up_down ? (r_count == i_reload_val) : (r_count == '0);
    endcase
  end

  // A load in the same cycle swallows the tick, so no terminal event either.
  assign w_tc_set = ~i_load & w_tick & w_terminal;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count  <= '0;
      r_active <= 1'b0;
      r_tc     <= 1'b0;
      r_flag   <= 1'b0;
    end else begin
      r_tc <= w_tc_set;
      if (i_load) begin
        r_count  <= w_start;
        r_active <= 1'b1;
      end else if (w_tick) begin
        if (w_terminal) begin
          case (w_mode)
            MODE_FREE:     r_count  <= i_up_down ? '0 : '1;
            MODE_PERIODIC: r_count  <= w_start;
            default:       r_active <= 1'b0;
          endcase
        end else begin
          r_count <= i_up_down ? r_count + c_ONE : r_count - c_ONE;
        end
      end
      if (w_tc_set) begin
        r_flag <= 1'b1;
      end else if (i_flag_clr) begin
        r_flag <= 1'b0;
      end
    end
  end

  assign o_count  = r_count;
  assign o_tc     = r_tc;
  assign o_flag   = r_flag;
  assign o_active = r_active;

endmodule

`default_nettype wire

// File: rtl/counter_bank.sv
// Bank of NCH independent counters sharing a prescaler strobe and an irq line.
// Optional prescaler built when COUNTER_BANK_PRESCALE_EN is defined.
`default_nettype none

module counter_bank
  import counter_pkg::*;
#(
  parameter int W       = 16,
  parameter int NCH     = 4,
  parameter int PRESC_W = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NCH-1:0]          load,
  input  logic [NCH-1:0]          en,
  input  logic [NCH-1:0]          up_down,
  input  logic [NCH*c_MODE_W-1:0] mode,
  input  logic [NCH*W-1:0]        reload_val,
  input  logic [NCH-1:0]          flag_clr,
  input  logic [NCH-1:0]          irq_mask,
  input  logic [PRESC_W-1:0]      presc_div,
  output logic [NCH*W-1:0]        count,
  output logic [NCH-1:0]          tc,
  output logic [NCH-1:0]          flag,
  output logic [NCH-1:0]          active,
  output logic                    irq
);

  logic w_strobe;

`ifdef COUNTER_BANK_PRESCALE_EN
  logic [PRESC_W-1:0] r_presc;

  assign w_strobe = (r_presc == presc_div);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_presc <= '0;
    end else if (w_strobe) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + PRESC_W'(1);
    end
  end
`else
  logic w_unused_presc;

  assign w_strobe       = 1'b1;
  assign w_unused_presc = ^presc_div;
`endif

  generate
    for (genvar g = 0; g < NCH; g++) begin : g_ch
      counter_channel #(
        .W (W)
      ) u_ch (
        .clk          (clk),
        .rst          (rst),
        .i_strobe     (w_strobe),
        .i_load       (load[g]),
        .i_en         (en[g]),
        .i_up_down    (up_down[g]),
        .i_mode       (mode[g*c_MODE_W +: c_MODE_W]),
        .i_reload_val (reload_val[g*W +: W]),
        .i_flag_clr   (flag_clr[g]),
        .o_count      (count[g*W +: W]),
        .o_tc         (tc[g]),
        .o_flag       (flag[g]),
        .o_active     (active[g])
      );
    end
  endgenerate

  assign irq = |(flag & irq_mask);

endmodule

`default_nettype wire

// File: doc/counter_bank.md
COUNTER_BANK -- requirements
Module: counter_bank

Interface
REQ-001 Parameter W, default 16: counter width in bits per channel, W >= 2.
REQ-002 Parameter NCH, default 4: number of independent channels, NCH >= 1.
REQ-003 Parameter PRESC_W, default 8: width of the shared prescaler divider.
REQ-004 clk  in  1: clock; all state changes on rising edge.
REQ-005 rst  in  1: reset, asynchronous, active-high.
REQ-006 load  in  NCH: per-channel start; loads the start value and sets the channel active.
REQ-007 en  in  NCH: per-channel count enable.
REQ-008 up_down  in  NCH: per-channel direction, 1 = up, 0 = down.
REQ-009 mode  in  NCH x 2: per-channel mode_t (FREE=00, PERIODIC=01, ONESHOT=10, HOLD=11).
REQ-010 reload_val  in  NCH x W: per-channel reload/limit value.
REQ-011 flag_clr  in  NCH: per-channel sticky-flag clear.
REQ-012 irq_mask  in  NCH: per-channel interrupt enable, 1 = enabled.
REQ-013 presc_div  in  PRESC_W: shared prescaler divide value.
REQ-014 count  out  NCH x W: per-channel current count.
REQ-015 tc  out  NCH: per-channel terminal-count pulse.
REQ-016 flag  out  NCH: per-channel sticky terminal flag.
REQ-017 active  out  NCH: per-channel running status.
REQ-018 irq  out  1: OR of (flag & irq_mask).

Function
REQ-019 Start value: up = 0, down = reload_val; load writes it to count and sets active in the next cycle.
REQ-020 Tick per channel: en & active & prescaler strobe, with mode != HOLD.
REQ-021 Priority per channel, highest first: rst, load, tick; a tick coinciding with load is discarded.
REQ-022 Terminal state: FREE up = all ones, FREE down = 0; PERIODIC/ONESHOT up = reload_val, down = 0.
REQ-023 Tick outside the terminal state: count +1 (up) or -1 (down), modulo 2^W.
REQ-024 Tick in the terminal state: FREE wraps (all ones -> 0, 0 -> all ones); PERIODIC reloads the start value; ONESHOT holds count and clears active.
REQ-025 Up-count above reload_val in PERIODIC/ONESHOT: increments modulo 2^W until reload_val is reached.
REQ-026 tc is registered; it is high for exactly one cycle, the cycle after a tick taken in the terminal state.
REQ-027 flag is set in the same cycle tc rises and held until flag_clr; simultaneous set and clear leaves flag = 1.
REQ-028 irq is combinational from the flag and irq_mask registers; no extra latency.
REQ-029 Changing mode, up_down or reload_val mid-count takes effect at the next tick; count is not modified.
REQ-030 HOLD freezes count and active; load still applies.

Reset
REQ-031 rst asserted: count = 0, tc = 0, flag = 0, active = 0, prescaler = 0, irq = 0, immediately and independent of clk.
REQ-032 The first tick is possible only after rst deassertion followed by a load.

Configuration
REQ-033 Macro COUNTER_BANK_PRESCALE_EN defined: a shared prescaler strobes once every presc_div+1 cycles (presc_div = 0 strobes every cycle) and free-runs from reset.
REQ-034 Macro not defined: the strobe is constant 1, presc_div is ignored, and no prescaler register is built.

Structure
REQ-035 Package counter_pkg holds the mode_t enum and the mode encodings.
REQ-036 Sub-module counter_channel, one per channel via generate, holds count, active, tc and flag; counter_bank holds the prescaler and the irq reduction.

Verification (W=8, NCH=4, presc_div=0)
REQ-037 ch0 PERIODIC down, reload_val=3, load then en=1 -> count 3,2,1,0,3,2...; tc pulses one cycle after each 0->3 step; flag=1; irq=1 when irq_mask[0]=1.
REQ-038 ch1 ONESHOT up, reload_val=5 -> count 0..5, then holds 5; single tc pulse; active=0; further en gives no change.
REQ-039 ch2 FREE up after load -> 255 wraps to 0 after 256 ticks with one tc pulse; down from 0 -> 255 with tc.
REQ-040 load together with en on ch0 mid-count -> count = start value with no tick; flag_clr and set in the same cycle -> flag=1; irq_mask=0 -> irq=0.
REQ-041 rst pulse between clock edges mid-count -> all outputs 0 before the next edge; ch idle until load.
REQ-042 Macro defined, presc_div=2 -> one tick per 3 cycles; macro undefined -> one tick per cycle.
